// File: rtl/path_reader.sv
// Drains the coordinate stack after the solver finishes, buffers the path and streams it out.
// Define PATH_READER_REVERSE_EN to emit start-to-end; otherwise entries leave in pop order.
module path_reader #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         stk_pop,
    input  logic [W-1:0] stk_x,
    input  logic [W-1:0] stk_y,
    input  logic         stk_fail,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StPop, StWait, StEmit} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic [W-1:0]  out_x_q, out_x_d;
    logic [W-1:0]  out_y_q, out_y_d;
    logic          last_q, last_d;

    logic [W-1:0]  mem_x_q [DEPTH];
    logic [W-1:0]  mem_y_q [DEPTH];

    logic          we;
    logic          load;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] first_idx;
    logic [IW-1:0] end_idx;
    logic [W-1:0]  rd_x;
    logic [W-1:0]  rd_y;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        we      = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPop;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StPop: state_d = StWait;
            StWait: begin
                if (stk_fail) begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StEmit;
                        load    = 1'b1;
                    end
                end else begin
                    we    = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(DEPTH)) begin
                        ovf_d   = 1'b1;
                        state_d = StEmit;
                        load    = 1'b1;
                    end else begin
                        state_d = StPop;
                    end
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
`ifdef PATH_READER_REVERSE_EN
                        idx_d = idx_q - IW'(1);
`else
                        idx_d = idx_q + IW'(1);
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        last_idx = IW'(cnt_d - CW'(1));
`ifdef PATH_READER_REVERSE_EN
        first_idx = last_idx;
        end_idx   = '0;
`else
        first_idx = '0;
        end_idx   = last_idx;
`endif
        if (state_q == StWait && load) begin
            idx_d = first_idx;
        end

        // The entry written on the overflowing WAIT is not in the buffer yet; forward it.
        rd_x = mem_x_q[idx_d];
        rd_y = mem_y_q[idx_d];
        if (we && idx_d == cnt_q[IW-1:0]) begin
            rd_x = stk_x;
            rd_y = stk_y;
        end

        out_x_d = load ? rd_x : out_x_q;
        out_y_d = load ? rd_y : out_y_q;
        if (load) begin
            last_d = (idx_d == end_idx);
        end else if (state_d != StEmit) begin
            last_d = 1'b0;
        end else begin
            last_d = last_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            out_x_q <= '0;
            out_y_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_x_q[cnt_q[IW-1:0]] <= stk_x;
            mem_y_q[cnt_q[IW-1:0]] <= stk_y;
        end
    end

    assign stk_pop   = (state_q == StPop);
    assign out_valid = (state_q == StEmit);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_path_reader.sv
// Self-checking bench for path_reader: a behavioural stack feeds the DUT and a scoreboard
// holds the expected beat sequence for each drain.
module tb_path_reader;

    localparam int W     = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stk_pop;
    logic [W-1:0] stk_x;
    logic [W-1:0] stk_y;
    logic         stk_fail;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         overflow;

    path_reader #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stk_pop  (stk_pop),
        .stk_x    (stk_x),
        .stk_y    (stk_y),
        .stk_fail (stk_fail),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stack model: tasks own the contents, this block owns the pop counters.
    logic [2*W-1:0] stk_mem [64];
    int             stk_n     = 0;
    int             succ_base = 0;
    int             succ_cnt  = 0;
    int             fail_cnt  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_x    <= '0;
            stk_y    <= '0;
            stk_fail <= 1'b0;
        end else if (stk_pop) begin
            if (succ_cnt - succ_base < stk_n) begin
                {stk_x, stk_y} <= stk_mem[stk_n - 1 - (succ_cnt - succ_base)];
                stk_fail       <= 1'b0;
                succ_cnt       <= succ_cnt + 1;
            end else begin
                stk_fail <= 1'b1;
                fail_cnt <= fail_cnt + 1;
            end
        end else begin
            stk_fail <= 1'b0;
        end
    end

    logic [2*W-1:0] plist [$];
    logic [2*W:0]   exp_q [$];
    logic [2*W:0]   got_q [$];
    logic [2*W:0]   prev_beat;
    bit             prev_stall;
    int             k;
    int             first_valid;
    int             done_at;
    int             done_cnt;
    int             stall_err;

    // Load the stack from plist (push order) and queue the beats the DUT should produce.
    task automatic arm();
        int n;
        int m;
        int p;
        n = plist.size();
        m = (n < DEPTH) ? n : DEPTH;
        for (int i = 0; i < n; i++) stk_mem[i] = plist[i];
        stk_n     = n;
        succ_base = succ_cnt;
        exp_q.delete();
        for (int i = 0; i < m; i++) begin
`ifdef PATH_READER_REVERSE_EN
            p = n - 1 - (m - 1 - i);
`else
            p = n - 1 - i;
`endif
            exp_q.push_back({(i == m - 1), plist[p]});
        end
    endtask

    // Observe one cycle at the negedge, then move to just after the next posedge.
    task automatic cycle();
        @(negedge clk);
        if (out_valid) begin
            if (first_valid < 0) first_valid = k;
            if (prev_stall && {out_last, out_x, out_y} !== prev_beat) stall_err++;
            if (out_ready) got_q.push_back({out_last, out_x, out_y});
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = {out_last, out_x, out_y};
        if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic begin_drain();
        got_q.delete();
        first_valid = -1;
        done_at     = -1;
        done_cnt    = 0;
        stall_err   = 0;
        prev_stall  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
    endtask

    task automatic run_until_done(input int budget);
        while (done_cnt == 0 && k < budget) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({stk_pop, out_valid, out_x, out_y, out_last, done, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0",
                     {stk_pop, out_valid, out_x, out_y, out_last, done, overflow});
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        @(posedge clk);
        #1;
        plist.delete();
        plist.push_back({4'd3, 4'd4});
        plist.push_back({4'd5, 4'd6});
        arm();
        out_ready = 1'b0;
        begin_drain();
        while (first_valid < 0 && k < 40) cycle();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_reach_emit got=%b want=1", out_valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({stk_pop, out_valid, out_x, out_y, out_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_mid_emit got=%b want=0",
                     {stk_pop, out_valid, out_x, out_y, out_last, busy, done});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle_after got=%b want=00", {busy, out_valid});
        end
    endtask

    task automatic test_single();
        int s0;
        int f0;
        logic [2*W:0] g;
        logic [2*W:0] e;
        plist.delete();
        plist.push_back({4'd1, 4'd0});
        arm();
        out_ready = 1'b1;
        s0 = succ_cnt;
        f0 = fail_cnt;
        begin_drain();
        run_until_done(40);
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL single_done got=%0d want=1", done_cnt);
        end
        total++;
        if (succ_cnt - s0 != 1 || fail_cnt - f0 != 1) begin
            bad++;
            $display("FAIL single_pops got=%0d/%0d want=1/1", succ_cnt - s0, fail_cnt - f0);
        end
        total++;
        if (first_valid != 4) begin
            bad++;
            $display("FAIL single_latency got=%0d want=4", first_valid);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL single_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL single_beat got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_three();
        logic [2*W:0] g;
        logic [2*W:0] e;
        plist.delete();
        plist.push_back({4'd1, 4'd0});
        plist.push_back({4'd2, 4'd0});
        plist.push_back({4'd2, 4'd1});
        arm();
        out_ready = 1'b1;
        begin_drain();
        run_until_done(40);
        total++;
        if (first_valid != 8) begin
            bad++;
            $display("FAIL three_latency got=%0d want=8", first_valid);
        end
        total++;
        if (got_q.size() != 3) begin
            bad++;
            $display("FAIL three_count got=%0d want=3", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL three_beat got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2*W:0] hold;
        logic [2*W:0] g;
        logic [2*W:0] e;
        plist.delete();
        for (int i = 0; i < 5; i++) plist.push_back(8'($urandom_range(0, 255)));
        arm();
        out_ready = 1'b0;
        begin_drain();
        while (first_valid < 0 && k < 60) cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        hold = {out_last, out_x, out_y};
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (out_valid !== 1'b1 || {out_last, out_x, out_y} !== hold) begin
                bad++;
                $display("FAIL bp_hold_%0d got=%b/%h want=1/%h", i, out_valid,
                         {out_last, out_x, out_y}, hold);
            end
        end
        out_ready = 1'b1;
        run_until_done(80);
        total++;
        if (stall_err != 0) begin
            bad++;
            $display("FAIL bp_stall_changes got=%0d want=0", stall_err);
        end
        total++;
        if (got_q.size() != 5) begin
            bad++;
            $display("FAIL bp_count got=%0d want=5", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL bp_beat got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_empty();
        int s0;
        int f0;
        plist.delete();
        arm();
        out_ready = 1'b1;
        s0 = succ_cnt;
        f0 = fail_cnt;
        begin_drain();
        run_until_done(20);
        repeat (3) cycle();
        total++;
        if (done_at != 2) begin
            bad++;
            $display("FAIL empty_done_at got=%0d want=2", done_at);
        end
        total++;
        if (first_valid != -1) begin
            bad++;
            $display("FAIL empty_valid got=%0d want=-1", first_valid);
        end
        total++;
        if (succ_cnt - s0 != 0 || fail_cnt - f0 != 1) begin
            bad++;
            $display("FAIL empty_pops got=%0d/%0d want=0/1", succ_cnt - s0, fail_cnt - f0);
        end
    endtask

    task automatic test_overflow();
        int s0;
        int f0;
        logic [2*W:0] g;
        logic [2*W:0] e;
        plist.delete();
        for (int i = 0; i < 18; i++) plist.push_back(8'($urandom_range(0, 255)));
        arm();
        out_ready = 1'b0;
        s0 = succ_cnt;
        f0 = fail_cnt;
        begin_drain();
        while (first_valid < 0 && k < 80) cycle();
        total++;
        if (first_valid != 2 * DEPTH) begin
            bad++;
            $display("FAIL ovf_latency got=%0d want=%0d", first_valid, 2 * DEPTH);
        end
        total++;
        if (succ_cnt - s0 != DEPTH || fail_cnt - f0 != 0) begin
            bad++;
            $display("FAIL ovf_pops got=%0d/%0d want=%0d/0", succ_cnt - s0, fail_cnt - f0,
                     DEPTH);
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag got=%b want=1", overflow);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        total++;
        if ({busy, out_valid} !== 2'b11 || succ_cnt - s0 != DEPTH) begin
            bad++;
            $display("FAIL ovf_start_ignored got=%b/%0d want=11/%0d", {busy, out_valid},
                     succ_cnt - s0, DEPTH);
        end
        out_ready = 1'b1;
        run_until_done(120);
        total++;
        if (got_q.size() != DEPTH) begin
            bad++;
            $display("FAIL ovf_count got=%0d want=%0d", got_q.size(), DEPTH);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL ovf_beat got=%h want=%h", g, e);
            end
        end
        total++;
        if (stk_n - (succ_cnt - s0) != 2 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_left got=%0d/%b want=2/1", stk_n - (succ_cnt - s0), overflow);
        end
        plist.delete();
        plist.push_back({4'd7, 4'd9});
        arm();
        begin_drain();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0", overflow);
        end
        run_until_done(40);
        total++;
        if (got_q.size() != 1 || done_cnt != 1) begin
            bad++;
            $display("FAIL ovf_next_drain got=%0d/%0d want=1/1", got_q.size(), done_cnt);
        end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL ovf_next_beat got=%h want=%h", g, e);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        k         = 0;
        test_reset();
        test_single();
        test_three();
        test_backpressure();
        test_empty();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
